// File: rtl/seg7_monitor_if.sv
// Signal bundle between a seven-segment driver and the monitor that decodes it.
// locked mirrors the monitor's FSM state (1 = LOCKED) for observation.
interface seg7_monitor_if;
  logic [6:0] segments;
  logic [3:0] digit;
  logic       digit_valid;
  logic       blank;
  logic       invalid;
  logic       invalid_seen;
  logic       seq_error;
  logic [7:0] digit_count;
  logic [7:0] err_count;
  logic       locked;

  modport master (
    output segments,
    input  digit, digit_valid, blank, invalid, invalid_seen, seq_error,
    input  digit_count, err_count, locked
  );

  modport slave (
    input  segments,
    output digit, digit_valid, blank, invalid, invalid_seen, seq_error,
    output digit_count, err_count, locked
  );
endinterface

// File: rtl/seg7_monitor.sv
// Debounces a seven-segment pattern, decodes it to hex, and checks that
// accepted digits count upward by one (mod 16).
module seg7_monitor #(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic          clk,
  input logic          rst,
  seg7_monitor_if.slave bus
);
  typedef enum logic {SETTLE, LOCKED} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

  state_t     state, state_next;
  logic [6:0] seg_q, seg_prev;
  logic [7:0] cnt, cnt_next;
  logic       changed, accept;
  logic [3:0] hex_val;
  logic       is_hex, is_blank;

  logic [3:0] digit_r, ref_digit;
  logic       seeded;
  logic       digit_valid_r, blank_r, invalid_r, invalid_seen_r, seq_error_r;
  logic [7:0] digit_count_r, err_count_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q    <= 7'h00;
      seg_prev <= 7'h00;
      state    <= SETTLE;
      cnt      <= 8'd0;
    end else begin
      seg_q    <= bus.segments;
      seg_prev <= seg_q;
      state    <= state_next;
      cnt      <= cnt_next;
    end
  end

  // The compare against seg_prev is what makes acceptance land STABLE_CYCLES
  // edges after the pattern first reaches seg_q.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    changed    = (seg_q != seg_prev);
    case (state)
      SETTLE: begin
        if (changed) begin
          cnt_next = 8'd0;
        end else begin
          cnt_next = cnt + 8'd1;
          if (cnt_next == LAST_COUNT) begin
            accept     = 1'b1;
            state_next = LOCKED;
          end
        end
      end
      LOCKED: begin
        if (changed) begin
          cnt_next   = 8'd0;
          state_next = SETTLE;
        end
      end
      default: state_next = SETTLE;
    endcase
  end

  always_comb begin
    hex_val  = 4'h0;
    is_hex   = 1'b1;
    is_blank = (seg_q == 7'h00);
    case (seg_q)
      7'h3F: hex_val = 4'h0;
      7'h06: hex_val = 4'h1;
      7'h5B: hex_val = 4'h2;
      7'h4F: hex_val = 4'h3;
      7'h66: hex_val = 4'h4;
      7'h6D: hex_val = 4'h5;
      7'h7D: hex_val = 4'h6;
      7'h07: hex_val = 4'h7;
      7'h7F: hex_val = 4'h8;
      7'h6F: hex_val = 4'h9;
      7'h77: hex_val = 4'hA;
      7'h7C: hex_val = 4'hB;
      7'h39: hex_val = 4'hC;
      7'h5E: hex_val = 4'hD;
      7'h79: hex_val = 4'hE;
      7'h71: hex_val = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      digit_r        <= 4'h0;
      ref_digit      <= 4'h0;
      seeded         <= 1'b0;
      digit_valid_r  <= 1'b0;
      blank_r        <= 1'b1;
      invalid_r      <= 1'b0;
      invalid_seen_r <= 1'b0;
      seq_error_r    <= 1'b0;
      digit_count_r  <= 8'd0;
      err_count_r    <= 8'd0;
    end else begin
      digit_valid_r <= 1'b0;
      invalid_r     <= 1'b0;
      seq_error_r   <= 1'b0;
      if (accept) begin
        if (is_hex) begin
          digit_r       <= hex_val;
          digit_valid_r <= 1'b1;
          blank_r       <= 1'b0;
          digit_count_r <= digit_count_r + 8'd1;
          ref_digit     <= hex_val;
          seeded        <= 1'b1;
          if (seeded && (hex_val != ref_digit + 4'd1)) begin
            seq_error_r <= 1'b1;
            if (err_count_r != 8'hFF) err_count_r <= err_count_r + 8'd1;
          end
        end else if (is_blank) begin
          blank_r <= 1'b1;
        end else begin
          invalid_r      <= 1'b1;
          invalid_seen_r <= 1'b1;
          blank_r        <= 1'b0;
        end
      end
    end
  end

  assign bus.digit        = digit_r;
  assign bus.digit_valid  = digit_valid_r;
  assign bus.blank        = blank_r;
  assign bus.invalid      = invalid_r;
  assign bus.invalid_seen = invalid_seen_r;
  assign bus.seq_error    = seq_error_r;
  assign bus.digit_count  = digit_count_r;
  assign bus.err_count    = err_count_r;
  assign bus.locked       = (state == LOCKED);
endmodule

// File: doc/seg7_monitor.md
SEG7_MONITOR -- requirements
Module: seg7_monitor

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..255: consecutive cycles a pattern must hold before acceptance.
REQ-002 SHALL have port clk, input, 1: the single clock, rising-edge; reset is synchronous and active-high.
REQ-003 SHALL have port rst, input, 1: synchronous active-high reset, sampled on the clk rising edge.
REQ-004 SHALL have port segments, input, 7: active-high segment drive, bit0=a … bit6=g.
REQ-005 SHALL have port digit, output, 4: hex value of the last accepted pattern.
REQ-006 SHALL have port digit_valid, output, 1: one-cycle pulse on each accepted hex pattern.
REQ-007 SHALL have port blank, output, 1: level, high while the last accepted pattern is 7'h00.
REQ-008 SHALL have port invalid, output, 1: one-cycle pulse on acceptance of an undecodable pattern.
REQ-009 SHALL have port invalid_seen, output, 1: sticky flag, set by any invalid pulse.
REQ-010 SHALL have port seq_error, output, 1: one-cycle pulse on an out-of-sequence digit.
REQ-011 SHALL have port digit_count, output, 8: accepted-digit counter, wraps modulo 256.
REQ-012 SHALL have port err_count, output, 8: seq_error counter, saturates at 255.

Function
REQ-013 SHALL register segments into seg_q every cycle (one input stage); all decisions SHALL use seg_q.
REQ-014 SHALL decode the table 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 B=7C C=39 D=5E E=79 F=71; 00 = blank; any other value = invalid.
REQ-015 SHALL implement FSM states SETTLE, LOCKED; on reset, state = SETTLE with the stability counter at 0.
REQ-016 SETTLE: if seg_q equals its previous value, the counter SHALL increment, else it SHALL clear to 0; when the counter reaches STABLE_CYCLES-1 with seg_q unchanged, the pattern SHALL be accepted and the state SHALL go to LOCKED.
REQ-017 LOCKED: any change of seg_q SHALL clear the counter and return the state to SETTLE; no output pulses SHALL occur while LOCKED.
REQ-018 Latency: for a pattern first present on segments at edge k and held, the acceptance outputs SHALL be valid in the cycle after edge k+STABLE_CYCLES.
REQ-019 Hex acceptance: digit SHALL update, digit_valid SHALL pulse, blank SHALL clear, and digit_count SHALL increment (255→0).
REQ-020 Blank acceptance: blank SHALL set; digit, digit_valid and both counters SHALL remain unchanged.
REQ-021 Invalid acceptance: invalid SHALL pulse and invalid_seen SHALL set; blank SHALL clear; digit SHALL hold.
REQ-022 Sequence check: the first hex acceptance after reset SHALL only seed the reference value; each later hex acceptance not equal to (reference+1) mod 16 SHALL pulse seq_error and increment err_count (saturating); the reference SHALL always update to the new digit.
REQ-023 Wrap: F followed by 0 SHALL be in sequence.
REQ-024 Blank and invalid acceptances SHALL NOT alter the sequence reference.
REQ-025 A change during SETTLE SHALL restart the count; a pattern shorter than STABLE_CYCLES SHALL produce no output.
REQ-026 At most one of digit_valid or invalid SHALL be high in any cycle; seq_error SHALL only coincide with digit_valid.

Reset
REQ-027 While rst is high: digit=0, digit_valid=0, blank=1, invalid=0, invalid_seen=0, seq_error=0, digit_count=0, err_count=0, seg_q=00, state=SETTLE, counter=0, sequence reference unseeded.
REQ-028 Reset asserted mid-SETTLE or while LOCKED SHALL discard all progress; after release, a held pattern SHALL need the full REQ-018 latency.

Verification
REQ-029 segments=06 held from edge 10 (STABLE_CYCLES=4) -> digit_valid high only in the cycle after edge 14; digit=1; digit_count=1; seq_error=0.
REQ-030 Sequence 0..F, then 0, each held 8 cycles -> 17 digit_valid pulses; digit_count=17; err_count=0; no seq_error (including at F→0).
REQ-031 Sequence 3F, 06, 4F (skipped 2) -> seq_error pulses with digit=3; err_count=1.
REQ-032 Glitch: 7F held 2 cycles between stable 3F and 06 -> no pulse for 7F; 06 is accepted in sequence; err_count=0.
REQ-033 Pattern 0x49 held 6 cycles -> one invalid pulse; invalid_seen stays 1; digit unchanged; then 00 held -> blank=1, no digit_valid.
REQ-034 rst pulsed 1 cycle mid-SETTLE, then 5B held -> all outputs at reset values during rst; first acceptance seeds the reference with no seq_error; digit=2.
